// File: rtl/sha_clk_enable_ctrl.sv
// Clock-enable sequencer for the SHA-256 core's clock gate: wakes the gated clock,
// issues start pulses only on a settled clock, and gates again after an idle timeout.
module sha_clk_enable_ctrl #(
  parameter int unsigned WAKE_CYCLES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_req,
  input  logic       sha_busy,
  input  logic       force_on,
  output logic       clk_enable,
  output logic       start_ack,
  output logic       sha_start,
  output logic [1:0] state_dbg
);

  // Handshake: start_req is a level held by the requester until it sees start_ack
  // high for one cycle; the requester drops start_req in that ack cycle, and any
  // request still visible in the ack cycle is ignored so it is never acked twice.

  typedef enum logic [1:0] {
    ST_GATED     = 2'b00,
    ST_WAKING    = 2'b01,
    ST_ACTIVE    = 2'b10,
    ST_IDLE_WAIT = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic cnt_last;
  logic req_grant;
  logic idle_cond;
  logic wake_event;

  assign cnt_last   = (cnt == CNT_ONE);
  assign req_grant  = start_req & ~sha_busy & ~start_ack;
  assign idle_cond  = ~start_req & ~sha_busy & ~force_on & ~start_ack;
  assign wake_event = sha_busy | force_on | start_req;

  assign state_dbg = state;

  // clk_enable is set alongside each state update so the gate only ever sees a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_GATED;
      cnt        <= '0;
      clk_enable <= 1'b0;
      start_ack  <= 1'b0;
      sha_start  <= 1'b0;
    end else begin
      start_ack <= 1'b0;
      sha_start <= 1'b0;
      case (state)
        ST_GATED: begin
          clk_enable <= 1'b0;
          if (start_req | force_on) begin
            state      <= ST_WAKING;
            cnt        <= WAKE_LOAD;
            clk_enable <= 1'b1;
          end
        end

        ST_WAKING: begin
          clk_enable <= 1'b1;
          if (cnt_last) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ST_ACTIVE: begin
          clk_enable <= 1'b1;
          if (req_grant) begin
            start_ack <= 1'b1;
            sha_start <= 1'b1;
          end else if (idle_cond) begin
            state <= ST_IDLE_WAIT;
            cnt   <= IDLE_LOAD;
          end
        end

        ST_IDLE_WAIT: begin
          clk_enable <= 1'b1;
          if (start_req & ~sha_busy) begin
            state     <= ST_ACTIVE;
            cnt       <= '0;
            start_ack <= 1'b1;
            sha_start <= 1'b1;
          end else if (wake_event) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
          end else if (cnt_last) begin
            state      <= ST_GATED;
            cnt        <= '0;
            clk_enable <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state      <= ST_GATED;
          cnt        <= '0;
          clk_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_clk_enable_ctrl.sv
// Bench for sha_clk_enable_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_sha_clk_enable_ctrl;

  localparam int WAKE = 2;
  localparam int IDLE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_req;
  logic       sha_busy;
  logic       force_on;
  logic       clk_enable;
  logic       start_ack;
  logic       sha_start;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  sha_clk_enable_ctrl #(
    .WAKE_CYCLES (WAKE),
    .IDLE_TIMEOUT(IDLE),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_req (start_req),
    .sha_busy  (sha_busy),
    .force_on  (force_on),
    .clk_enable(clk_enable),
    .start_ack (start_ack),
    .sha_start (sha_start),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 off, 1 waking, 2 running, 3 idling; elapsed counts up.
  int       m_mode = 0;
  int       m_elapsed = 0;
  logic     m_ack = 1'b0;
  logic [4:0] exp_q[$];

  always @(posedge clk) begin : model
    logic prev_ack;
    prev_ack = m_ack;
    m_ack    = 1'b0;
    if (rst) begin
      m_mode    = 0;
      m_elapsed = 0;
    end else begin
      case (m_mode)
        0: if (start_req || force_on) begin
             m_mode    = 1;
             m_elapsed = 0;
           end
        1: begin
             m_elapsed++;
             if (m_elapsed == WAKE) m_mode = 2;
           end
        2: if (start_req && !sha_busy && !prev_ack) m_ack = 1'b1;
           else if (!start_req && !sha_busy && !force_on && !prev_ack) begin
             m_mode    = 3;
             m_elapsed = 0;
           end
        default: if (start_req && !sha_busy) begin
                   m_mode = 2;
                   m_ack  = 1'b1;
                 end else if (sha_busy || force_on || start_req) m_mode = 2;
                 else begin
                   m_elapsed++;
                   if (m_elapsed == IDLE) m_mode = 0;
                 end
      endcase
    end
    exp_q.push_back({m_mode[1:0], (m_mode != 0), m_ack, m_ack});
  end

  // scoreboard compare
  always @(negedge clk) begin : cmp
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL model_queue: got empty expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk2("m_state_dbg", state_dbg, e[4:3]);
      chk1("m_clk_enable", clk_enable, e[2]);
      chk1("m_start_ack", start_ack, e[1]);
      chk1("m_sha_start", sha_start, e[0]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin : stim
    int busy_left;
    busy_left = 0;
    rst = 1'b1; start_req = 1'b1; sha_busy = 1'b0; force_on = 1'b0;

    // reset held with a request present
    repeat (3) begin
      tick();
      chk1("rst_en", clk_enable, 1'b0);
      chk1("rst_ack", start_ack, 1'b0);
      chk1("rst_start", sha_start, 1'b0);
      chk2("rst_state", state_dbg, 2'b00);
    end
    rst = 1'b0;

    // cold start
    tick(); chk1("cold_en_e0", clk_enable, 1'b1); chk2("cold_state_e0", state_dbg, 2'b01);
    tick(); chk2("cold_state_e1", state_dbg, 2'b01); chk1("cold_ack_e1", start_ack, 1'b0);
    tick(); chk2("cold_state_e2", state_dbg, 2'b10); chk1("cold_ack_e2", start_ack, 1'b0);
    tick(); chk1("cold_ack_e3", start_ack, 1'b1); chk1("cold_start_e3", sha_start, 1'b1);
    tick(); chk1("cold_no_double_ack", start_ack, 1'b0); chk1("cold_no_double_start", sha_start, 1'b0);
    start_req = 1'b0; sha_busy = 1'b1;

    // busy, then timeout to gated
    repeat (10) begin
      tick(); chk1("busy_no_ack", start_ack, 1'b0); chk2("busy_state", state_dbg, 2'b10);
    end
    sha_busy = 1'b0;
    tick(); chk2("idle_entry_state", state_dbg, 2'b11);
    for (int k = 1; k < IDLE; k++) begin
      tick(); chk1("timeout_en_held", clk_enable, 1'b1);
    end
    tick(); chk1("timeout_gated_en", clk_enable, 1'b0); chk2("timeout_gated_state", state_dbg, 2'b00);

    // wake via force, idle, then request at idle count 5
    force_on = 1'b1;
    tick(); chk2("force_wake_state", state_dbg, 2'b01);
    force_on = 1'b0;
    tick(); chk2("wake_w1_state", state_dbg, 2'b01);
    tick(); chk2("wake_w2_state", state_dbg, 2'b10);
    tick(); chk2("idle2_entry_state", state_dbg, 2'b11);
    repeat (4) begin
      tick(); chk1("idle2_en", clk_enable, 1'b1); chk2("idle2_state", state_dbg, 2'b11);
    end
    start_req = 1'b1;
    tick(); chk1("idle_wake_ack", start_ack, 1'b1); chk2("idle_wake_state", state_dbg, 2'b10);
    chk1("idle_wake_en", clk_enable, 1'b1);
    start_req = 1'b0; sha_busy = 1'b1;
    tick(); chk1("idle_wake_ack_end", start_ack, 1'b0);

    // request while busy
    start_req = 1'b1;
    repeat (5) begin
      tick(); chk1("req_busy_no_ack", start_ack, 1'b0);
    end
    sha_busy = 1'b0;
    tick(); chk1("req_after_busy_ack", start_ack, 1'b1); chk1("req_after_busy_start", sha_start, 1'b1);
    start_req = 1'b0;
    tick(); chk1("req_after_busy_ack_end", start_ack, 1'b0);

    // force_on holds the clock, then timeout after release
    force_on = 1'b1;
    repeat (100) begin
      tick(); chk1("force_en_held", clk_enable, 1'b1);
    end
    force_on = 1'b0;
    repeat (IDLE) begin
      tick(); chk1("force_release_en", clk_enable, 1'b1);
    end
    tick(); chk1("force_release_gated", clk_enable, 1'b0); chk2("force_release_state", state_dbg, 2'b00);

    // reset during the first waking cycle
    start_req = 1'b1;
    tick(); chk2("mid_wake_state", state_dbg, 2'b01);
    rst = 1'b1;
    tick(); chk1("mid_wake_rst_en", clk_enable, 1'b0); chk2("mid_wake_rst_state", state_dbg, 2'b00);
    rst = 1'b0; start_req = 1'b0;
    repeat (6) begin
      tick(); chk1("mid_wake_no_ack", start_ack, 1'b0); chk1("mid_wake_stay_off", clk_enable, 1'b0);
    end

    // randomized traffic; the model compare checks every cycle
    repeat (4000) begin
      tick();
      rst = 1'b0;
      if (busy_left > 0) begin
        sha_busy = 1'b1;
        busy_left--;
      end else begin
        sha_busy = 1'b0;
      end
      if (sha_start) busy_left = $urandom_range(1, 12);
      if (start_req && start_ack) start_req = 1'b0;
      else if (!start_req && $urandom_range(0, 5) == 0) start_req = 1'b1;
      if (force_on) begin
        if ($urandom_range(0, 19) == 0) force_on = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        force_on = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        start_req = 1'b0;
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
